pipeline_perf_monitor: RTL

//  Hardware run-control and performance monitor for cpu_pipelined. Counts cycles and
//  NUM_EVENTS event channels (retire, stall, flush, ...) from start until end_program.

---
 rtl/pipeline_perf_monitor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipeline_perf_monitor.sv
// rtl/pipeline_perf_monitor.sv - run-control FSM with cycle/event counters and a post-program drain window
// Optional feature macro: PERF_SATURATE_EN (counters saturate at all-ones instead of wrapping).
module pipeline_perf_monitor #(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned NUM_EVENTS   = 4,
    parameter int unsigned SEL_WIDTH    = 2,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  end_program,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_ovf,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  cycle_ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int unsigned DW         = $clog2(DRAIN_LOAD + 2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [DW-1:0]          r_drain;
    logic [DW-1:0]          w_next_drain;
    logic                   w_zero;
    logic                   w_count;
    logic [CNT_WIDTH-1:0]   r_cycle;
    logic                   r_cycle_ovf;
    logic [CNT_WIDTH-1:0]   r_evt_cnt [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]  r_evt_ovf;

    // All-ones detection drives the overflow flag in both modes; only the stored value differs.
    function automatic logic [CNT_WIDTH-1:0] f_inc(input logic [CNT_WIDTH-1:0] v);
`ifdef PERF_SATURATE_EN
        return (&v) ? v : v + CNT_ONE;
`else
        return v + CNT_ONE;
`endif
    endfunction

    always_comb begin
        w_next_state = r_state;
        w_next_drain = r_drain;
        w_zero       = 1'b0;
        w_count      = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !clear;
        if (clear) begin
            w_next_state = S_IDLE;
            w_next_drain = '0;
            w_zero       = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next_state = S_RUN;
                        w_zero       = 1'b1;
                    end
                end
                S_RUN: begin
                    if (end_program) begin
                        if (DRAIN_CYCLES == 0) begin
                            w_next_state = S_DONE;
                        end else begin
                            w_next_state = S_DRAIN;
                            w_next_drain = DW'(DRAIN_LOAD);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_drain = r_drain - DW'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        w_next_state = S_RUN;
                        w_zero       = 1'b1;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drain     <= '0;
            r_cycle     <= '0;
            r_cycle_ovf <= 1'b0;
            r_evt_ovf   <= '0;
            for (int k = 0; k < NUM_EVENTS; k++) begin
                r_evt_cnt[k] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_drain <= w_next_drain;
            if (w_zero) begin
                r_cycle     <= '0;
                r_cycle_ovf <= 1'b0;
                r_evt_ovf   <= '0;
                for (int k = 0; k < NUM_EVENTS; k++) begin
                    r_evt_cnt[k] <= '0;
                end
            end else if (w_count) begin
                r_cycle <= f_inc(r_cycle);
                if (&r_cycle) begin
                    r_cycle_ovf <= 1'b1;
                end
                for (int k = 0; k < NUM_EVENTS; k++) begin
                    if (event_i[k]) begin
                        r_evt_cnt[k] <= f_inc(r_evt_cnt[k]);
                        if (&r_evt_cnt[k]) begin
                            r_evt_ovf[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Selects beyond NUM_EVENTS never match and fall through to zero.
    always_comb begin
        rd_data = '0;
        rd_ovf  = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            if (rd_sel == SEL_WIDTH'(k)) begin
                rd_data = r_evt_cnt[k];
                rd_ovf  = r_evt_ovf[k];
            end
        end
    end

    assign cycle_count = r_cycle;
    assign cycle_ovf   = r_cycle_ovf;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);

endmodule
